mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mau_pkg.sv | 45 ++++
 rtl/lane_align.sv | 51 +++++
 rtl/mem_access_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/mau_pkg.sv
// Purpose: shared types and constants for the CPU-side memory access unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mau_pkg;

   // Default data memory depth in 32-bit words.
   localparam int MAU_MEM_WORDS = 256;

   // Access size encodings carried on the size port.
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      WRITE = 3'd2,
      DONE  = 3'd3,
      ERR   = 3'd4
   } mau_state_t;

   // Request fields captured on acceptance.
   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic        sign_ext;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mau_req_t;

   // Illegal size or natural-alignment violation for the given byte offset.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      logic bad;
      bad = 1'b0;
      case (size)
         SZ_HALF: bad = off[0];
         SZ_WORD: bad = (off != 2'b00);
         SZ_ILL:  bad = 1'b1;
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lane_align.sv
// Purpose: little-endian lane extract/extend for loads and lane merge for sub-word stores.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
//
// Ports:
//   size, offset, sign_ext : access size, addr[1:0], load extension mode
//   rd_word                : word the load lane is taken from
//   base_word, wdata       : word to merge into, right-aligned store data
//   load_val               : extracted lane extended to 32 bits
//   merge_word             : base_word with addressed lane replaced (wdata for a word store)
module lane_align
   import mau_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic        sign_ext,
   input  logic [31:0] rd_word,
   input  logic [31:0] base_word,
   input  logic [31:0] wdata,
   output logic [31:0] load_val,
   output logic [31:0] merge_word
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rd_word[{offset, 3'b000} +: 8];
      half_sel = offset[1] ? rd_word[31:16] : rd_word[15:0];

      load_val = rd_word;
      case (size)
         SZ_BYTE: load_val = {{24{sign_ext & byte_sel[7]}}, byte_sel};
         SZ_HALF: load_val = {{16{sign_ext & half_sel[15]}}, half_sel};
         default: load_val = rd_word;
      endcase
   end

   always_comb begin
      merge_word = base_word;
      case (size)
         SZ_BYTE: merge_word[{offset, 3'b000} +: 8] = wdata[7:0];
         SZ_HALF: begin
            if (offset[1]) merge_word[31:16] = wdata[15:0];
            else           merge_word[15:0]  = wdata[15:0];
         end
         default: merge_word = wdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Purpose: turns CPU byte/half/word load-store requests into word accesses on a simple memory.
// Latency: ack 1 cycle after accept on error, 2 for load or word store, 3 for sub-word store (read-modify-write).
// Backpressure: busy is high outside IDLE; req is only sampled in IDLE and is ignored otherwise.
//
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   req, we, size, sign_ext, addr,
//   wdata                           : CPU request
//   ack, err, rdata, busy           : CPU completion / status
//   ReadMem, WriteMem, Addr, Data_i : memory read/write enables, word index, write data
//   Data                            : memory read data (combinational on ReadMem/Addr)
module mem_access_unit
   import mau_pkg::*;
#(
   parameter int MEM_WORDS = MAU_MEM_WORDS
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ack,
   output logic        err,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        ReadMem,
   output logic        WriteMem,
   output logic [31:0] Addr,
   output logic [31:0] Data_i,
   input  logic [31:0] Data
);

   localparam int          AW     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [31:0] WORDS  = 32'(MEM_WORDS);

   mau_state_t  state_q, state_d;
   mau_req_t    req_q;
   logic [31:0] word_q;
   logic [31:0] rdata_q;
   logic        req_bad;
   logic [31:0] load_val;
   logic [31:0] merge_word;
   logic        unused_addr_bits;

   // Bounds test uses the full word index so high address bits cannot alias into range.
   assign req_bad = misaligned(size, addr[1:0]) || ({2'b00, addr[31:2]} >= WORDS);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               if (req_bad)                    state_d = ERR;
               else if (we && size == SZ_WORD) state_d = WRITE;
               else                            state_d = READ;
            end
         end
         READ:    state_d = req_q.we ? WRITE : DONE;
         WRITE:   state_d = DONE;
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         req_q   <= '0;
         word_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && req) begin
            req_q.we       <= we;
            req_q.size     <= size;
            req_q.sign_ext <= sign_ext;
            req_q.addr     <= addr;
            req_q.wdata    <= wdata;
         end
         if (state_q == READ) begin
            word_q <= Data;
            // Extract straight from Data so rdata is already valid in the DONE/ack cycle.
            if (!req_q.we) rdata_q <= load_val;
         end
      end
   end

   lane_align u_lane_align (
      .size       (req_q.size),
      .offset     (req_q.addr[1:0]),
      .sign_ext   (req_q.sign_ext),
      .rd_word    (Data),
      .base_word  (word_q),
      .wdata      (req_q.wdata),
      .load_val   (load_val),
      .merge_word (merge_word)
   );

   assign ack      = (state_q == DONE) || (state_q == ERR);
   assign err      = (state_q == ERR);
   assign busy     = (state_q != IDLE);
   assign ReadMem  = (state_q == READ);
   assign WriteMem = (state_q == WRITE);
   assign rdata    = rdata_q;
   assign Addr     = {{(32-AW){1'b0}}, req_q.addr[AW+1:2]};
   // Word stores pass wdata through; sub-word stores merge into the word read in READ.
   assign Data_i   = merge_word;

   // Address bits above the memory index only matter for the bounds test at accept time.
   assign unused_addr_bits = ^req_q.addr;

endmodule
